csr_access_ctrl: RTL and testbench
==================================

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 Parameter ECODE_INT, default 6'h00: ecode reported for a taken interrupt.
REQ-002 Parameter WE_ALL, default 4'hf: csr_we value driven during a CSR write.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 ws_valid  in  1  writeback-stage instruction valid.
REQ-006 ws_ready  out  1  controller can accept an instruction.
REQ-007 ws_op  in  3  0 NONE, 1 CSRRD, 2 CSRWR, 3 CSRXCHG, 4 ERTN; 5-7 treated as NONE.
REQ-008 ws_csr_num  in  14  CSR number.
REQ-009 ws_rj_value / ws_rd_value  in  32 each  xchg mask / write data.
REQ-010 ws_dest  in  5  GPR destination.
REQ-011 ws_pc  in  32  instruction PC.
REQ-012 ws_ex, ws_ecode, ws_esubcode  in  1/6/9  upstream-detected exception.
REQ-013 csr_re, csr_rnum  out  1/14  CSR read request and number.
REQ-014 csr_rdata  in  32  combinational read data for csr_rnum.
REQ-015 csr_we, csr_wnum, csr_wmask, csr_wdata  out  4/14/32/32  CSR write port.
REQ-016 wb_ex, wb_ecode, wb_esubcode, wb_pc  out  1/6/9/32  exception commit to CSR file.
REQ-017 ertn_flush  out  1  ertn commit to CSR file.
REQ-018 has_int, excp_pc, ertn_pc  in  1/32/32  pending interrupt, exception entry, return address.
REQ-019 rf_we, rf_waddr, rf_wdata  out  1/5/32  GPR writeback of old CSR value.
REQ-020 flush, flush_pc  out  1/32  pipeline flush and redirect target.

Function
REQ-021 States: IDLE, READ, WRITE, DONE, EXC, ERTN, FLUSH; ws_ready=1 only in IDLE.
REQ-022 Accept = ws_valid & ws_ready; on accept latch op, csr_num, rj, rd_value, dest, pc, ex, ecode, esubcode, and has_int.
REQ-023 Priority at accept: has_int > ws_ex > ERTN > CSR op > NONE.
REQ-024 has_int at accept -> EXC with ecode=ECODE_INT, esubcode=0, pc=ws_pc; instruction not executed.
REQ-025 ws_ex at accept -> EXC with the latched ecode/esubcode/pc; no CSR read/write.
REQ-026 NONE -> remain IDLE; consumed in one cycle, no outputs.
REQ-027 CSRRD/CSRWR/CSRXCHG -> READ: csr_re=1, csr_rnum=num; capture csr_rdata at end of cycle.
REQ-028 READ -> DONE for CSRRD; READ -> WRITE otherwise.
REQ-029 WRITE: csr_we=WE_ALL, csr_wnum=num, csr_wdata=rd_value, csr_wmask=32'hffffffff (CSRWR) or rj_value (CSRXCHG); exactly one cycle.
REQ-030 DONE: rf_we=1 (suppressed if dest==0), rf_waddr=dest, rf_wdata=captured old value; -> IDLE.
REQ-031 Latency accept-edge to rf_we: CSRRD 2 cycles, CSRWR/CSRXCHG 3 cycles.
REQ-032 EXC: wb_ex=1 for exactly one cycle with latched ecode/esubcode/pc; latch excp_pc as target; -> FLUSH.
REQ-033 ERTN: ertn_flush=1 for exactly one cycle; latch ertn_pc as target; -> FLUSH.
REQ-034 FLUSH: flush=1 for one cycle, flush_pc=latched target; -> IDLE.
REQ-035 csr_we=0, csr_re=0, wb_ex=0, ertn_flush=0, rf_we=0, flush=0 in all states not listed above.
REQ-036 Changes on ws_* or has_int after accept do not affect the in-flight operation.
REQ-037 wb_ex and ertn_flush never assert in the same cycle; csr_we never asserts with wb_ex.

Reset
REQ-038 resetn low -> state IDLE immediately, regardless of operation in flight; aborted operations produce no further outputs.
REQ-039 During and after reset until first accept: all strobes 0, all data/number outputs 0, ws_ready=1 once resetn is high.

Verification
REQ-040 CSRRD num=0x30, csr_rdata=0x1234, dest=5 -> csr_re in cycle 1; rf_we, waddr=5, wdata=0x1234 in cycle 2; no csr_we.
REQ-041 CSRXCHG num=0x0, rj=0x3, rd_value=0x7, old=0x8 -> cycle 2: csr_we=4'hf, wmask=0x3, wdata=0x7; cycle 3: rf_wdata=0x8.
REQ-042 Instruction with ws_ex=1, ecode=0x0B, pc=0x1c000100, excp_pc=0x1c008000 -> wb_ex one cycle with those values; next cycle flush=1, flush_pc=0x1c008000.
REQ-043 has_int=1 together with CSRWR -> wb_ex, ecode=0x00, no csr_we, then flush to excp_pc.
REQ-044 ERTN with ertn_pc=0x1c000204 -> ertn_flush one cycle, then flush=1, flush_pc=0x1c000204.
REQ-045 resetn low during WRITE -> csr_we drops immediately, state IDLE, no rf_we; a new CSRRD after reset completes normally.

Source files
------------

// File: rtl/csr_access_ctrl.sv
// Writeback-stage CSR access / exception / ertn sequencer; CSRRD rf write 2 cycles after accept, CSRWR/XCHG 3.
// Backpressure: ws_ready is high only while idle; every accepted instruction runs to completion unless reset.
module csr_access_ctrl #(
    parameter logic [5:0] ECODE_INT = 6'h00,
    parameter logic [3:0] WE_ALL    = 4'hf
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    output logic        ws_ready,
    input  logic [2:0]  ws_op,
    input  logic [13:0] ws_csr_num,
    input  logic [31:0] ws_rj_value,
    input  logic [31:0] ws_rd_value,
    input  logic [4:0]  ws_dest,
    input  logic [31:0] ws_pc,
    input  logic        ws_ex,
    input  logic [5:0]  ws_ecode,
    input  logic [8:0]  ws_esubcode,
    output logic        csr_re,
    output logic [13:0] csr_rnum,
    input  logic [31:0] csr_rdata,
    output logic [3:0]  csr_we,
    output logic [13:0] csr_wnum,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wdata,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic        ertn_flush,
    input  logic        has_int,
    input  logic [31:0] excp_pc,
    input  logic [31:0] ertn_pc,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush,
    output logic [31:0] flush_pc
);

    localparam logic [2:0] OP_CSRRD   = 3'd1;
    localparam logic [2:0] OP_CSRWR   = 3'd2;
    localparam logic [2:0] OP_CSRXCHG = 3'd3;
    localparam logic [2:0] OP_ERTN    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_EXC,
        S_ERTN,
        S_FLUSH
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;

    logic [2:0]  r_op;
    logic [13:0] r_num;
    logic [31:0] r_rj;
    logic [31:0] r_rd;
    logic [4:0]  r_dest;
    logic [31:0] r_pc;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esub;
    logic        r_int;
    logic [31:0] r_old;
    logic [31:0] r_target;

    assign w_accept = ws_valid & ws_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Everything the sequence needs is frozen at accept; later ws_*/has_int changes are ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op     <= '0;
            r_num    <= '0;
            r_rj     <= '0;
            r_rd     <= '0;
            r_dest   <= '0;
            r_pc     <= '0;
            r_ecode  <= '0;
            r_esub   <= '0;
            r_int    <= 1'b0;
            r_old    <= '0;
            r_target <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= ws_op;
                r_num   <= ws_csr_num;
                r_rj    <= ws_rj_value;
                r_rd    <= ws_rd_value;
                r_dest  <= ws_dest;
                r_pc    <= ws_pc;
                r_ecode <= ws_ecode;
                r_esub  <= ws_esubcode;
                r_int   <= has_int;
            end
            if (r_state == S_READ) begin
                r_old <= csr_rdata;
            end
            if (r_state == S_EXC) begin
                r_target <= excp_pc;
            end else if (r_state == S_ERTN) begin
                r_target <= ertn_pc;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        ws_ready    = 1'b0;
        csr_re      = 1'b0;
        csr_rnum    = '0;
        csr_we      = '0;
        csr_wnum    = '0;
        csr_wmask   = '0;
        csr_wdata   = '0;
        wb_ex       = 1'b0;
        wb_ecode    = '0;
        wb_esubcode = '0;
        wb_pc       = '0;
        ertn_flush  = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        flush       = 1'b0;
        flush_pc    = '0;

        case (r_state)
            S_IDLE: begin
                ws_ready = resetn;
                if (w_accept) begin
                    // Interrupt and upstream exception pre-empt the instruction itself.
                    if (has_int || ws_ex) begin
                        w_next = S_EXC;
                    end else begin
                        case (ws_op)
                            OP_ERTN:                         w_next = S_ERTN;
                            OP_CSRRD, OP_CSRWR, OP_CSRXCHG:  w_next = S_READ;
                            default:                         w_next = S_IDLE;
                        endcase
                    end
                end
            end
            S_READ: begin
                csr_re   = 1'b1;
                csr_rnum = r_num;
                w_next   = (r_op == OP_CSRRD) ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                csr_we    = WE_ALL;
                csr_wnum  = r_num;
                csr_wdata = r_rd;
                csr_wmask = (r_op == OP_CSRXCHG) ? r_rj : 32'hffff_ffff;
                w_next    = S_DONE;
            end
            S_DONE: begin
                rf_we    = (r_dest != 5'd0);
                rf_waddr = r_dest;
                rf_wdata = r_old;
                w_next   = S_IDLE;
            end
            S_EXC: begin
                wb_ex       = 1'b1;
                wb_ecode    = r_int ? ECODE_INT : r_ecode;
                wb_esubcode = r_int ? 9'd0 : r_esub;
                wb_pc       = r_pc;
                w_next      = S_FLUSH;
            end
            S_ERTN: begin
                ertn_flush = 1'b1;
                w_next     = S_FLUSH;
            end
            S_FLUSH: begin
                flush    = 1'b1;
                flush_pc = r_target;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    a_commit_exclusive: assert property (@(posedge clk) disable iff (!resetn)
        !(wb_ex && (ertn_flush || (csr_we != 4'd0))));

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: directed vector table, reset-in-flight sequence and randomized
// transactions scored against a per-cycle trace model of each instruction type.
module tb_csr_access_ctrl;

    typedef struct packed {
        logic        ready;
        logic        re;
        logic [13:0] rnum;
        logic [3:0]  we;
        logic [13:0] wnum;
        logic [31:0] wmask;
        logic [31:0] wdata;
        logic        wbex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] wbpc;
        logic        ertn;
        logic        rfwe;
        logic [4:0]  waddr;
        logic [31:0] rfwdata;
        logic        flush;
        logic [31:0] fpc;
    } obs_t;

    typedef obs_t [3:0] trace_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [13:0] num;
        logic [31:0] rj;
        logic [31:0] rd;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic        hasint;
    } txn_t;

    // rdv/xpv/epv: csr_rdata, excp_pc, ertn_pc driven during cycle k after accept.
    typedef struct packed {
        txn_t             t;
        logic [3:0][31:0] rdv;
        logic [3:0][31:0] xpv;
        logic [3:0][31:0] epv;
        trace_t           exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_valid;
    logic        ws_ready;
    logic [2:0]  ws_op;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_rj_value;
    logic [31:0] ws_rd_value;
    logic [4:0]  ws_dest;
    logic [31:0] ws_pc;
    logic        ws_ex;
    logic [5:0]  ws_ecode;
    logic [8:0]  ws_esubcode;
    logic        csr_re;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rdata;
    logic [3:0]  csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic        has_int;
    logic [31:0] excp_pc;
    logic [31:0] ertn_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush;
    logic [31:0] flush_pc;

    obs_t act;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    csr_access_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .ws_valid    (ws_valid),
        .ws_ready    (ws_ready),
        .ws_op       (ws_op),
        .ws_csr_num  (ws_csr_num),
        .ws_rj_value (ws_rj_value),
        .ws_rd_value (ws_rd_value),
        .ws_dest     (ws_dest),
        .ws_pc       (ws_pc),
        .ws_ex       (ws_ex),
        .ws_ecode    (ws_ecode),
        .ws_esubcode (ws_esubcode),
        .csr_re      (csr_re),
        .csr_rnum    (csr_rnum),
        .csr_rdata   (csr_rdata),
        .csr_we      (csr_we),
        .csr_wnum    (csr_wnum),
        .csr_wmask   (csr_wmask),
        .csr_wdata   (csr_wdata),
        .wb_ex       (wb_ex),
        .wb_ecode    (wb_ecode),
        .wb_esubcode (wb_esubcode),
        .wb_pc       (wb_pc),
        .ertn_flush  (ertn_flush),
        .has_int     (has_int),
        .excp_pc     (excp_pc),
        .ertn_pc     (ertn_pc),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .flush       (flush),
        .flush_pc    (flush_pc)
    );

    assign act = {ws_ready, csr_re, csr_rnum, csr_we, csr_wnum, csr_wmask, csr_wdata,
                  wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush,
                  rf_we, rf_waddr, rf_wdata, flush, flush_pc};

    task automatic check(input obs_t a, input obs_t e, input string nm);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic check_quiet(input string nm);
        obs_t m;
        m = act;
        m.ready = 1'b0;
        check(m, '0, nm);
    endtask

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    task automatic junk();
        ws_valid    = 1'b1;
        ws_op       = 3'($urandom);
        ws_csr_num  = 14'($urandom);
        ws_rj_value = $urandom;
        ws_rd_value = $urandom;
        ws_dest     = 5'($urandom);
        ws_pc       = $urandom;
        ws_ex       = 1'($urandom);
        ws_ecode    = 6'($urandom);
        ws_esubcode = 9'($urandom);
        has_int     = 1'($urandom);
    endtask

    task automatic apply(input txn_t t);
        ws_valid    = 1'b1;
        ws_op       = t.op;
        ws_csr_num  = t.num;
        ws_rj_value = t.rj;
        ws_rd_value = t.rd;
        ws_dest     = t.dest;
        ws_pc       = t.pc;
        ws_ex       = t.ex;
        ws_ecode    = t.ecode;
        ws_esubcode = t.esub;
        has_int     = t.hasint;
    endtask

    // What each instruction class should look like on the outputs, cycle by cycle after accept.
    function automatic trace_t model(input vec_t v);
        trace_t tr;
        obs_t   d;
        for (int k = 0; k < 4; k++) tr[k] = idle_obs();
        d         = '0;
        d.rfwe    = (v.t.dest != 5'd0);
        d.waddr   = v.t.dest;
        d.rfwdata = v.rdv[0];
        if (v.t.hasint || v.t.ex) begin
            tr[0]       = '0;
            tr[0].wbex  = 1'b1;
            tr[0].ecode = v.t.hasint ? 6'h00 : v.t.ecode;
            tr[0].esub  = v.t.hasint ? 9'd0 : v.t.esub;
            tr[0].wbpc  = v.t.pc;
            tr[1]       = '0;
            tr[1].flush = 1'b1;
            tr[1].fpc   = v.xpv[0];
        end else if (v.t.op == 3'd4) begin
            tr[0]       = '0;
            tr[0].ertn  = 1'b1;
            tr[1]       = '0;
            tr[1].flush = 1'b1;
            tr[1].fpc   = v.epv[0];
        end else if (v.t.op >= 3'd1 && v.t.op <= 3'd3) begin
            tr[0]      = '0;
            tr[0].re   = 1'b1;
            tr[0].rnum = v.t.num;
            if (v.t.op == 3'd1) begin
                tr[1] = d;
            end else begin
                tr[1]       = '0;
                tr[1].we    = 4'hf;
                tr[1].wnum  = v.t.num;
                tr[1].wmask = (v.t.op == 3'd3) ? v.t.rj : 32'hffff_ffff;
                tr[1].wdata = v.t.rd;
                tr[2]       = d;
            end
        end
        return tr;
    endfunction

    // Entered just after a falling edge with the DUT idle; leaves it the same way.
    task automatic run_txn(input vec_t v, input string nm);
        apply(v.t);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            csr_rdata = v.rdv[k];
            excp_pc   = v.xpv[k];
            ertn_pc   = v.epv[k];
            if (v.exp[k].ready) ws_valid = 1'b0;
            else junk();
            #1 check(act, v.exp[k], $sformatf("%s c%0d", nm, k));
        end
    endtask

    vec_t  dirv [7];
    string dnames [7];

    initial begin
        vec_t v;

        for (int i = 0; i < 7; i++) begin
            dirv[i] = '0;
            for (int k = 0; k < 4; k++) dirv[i].exp[k] = idle_obs();
        end

        dnames[0] = "csrrd";
        dirv[0].t.op = 3'd1; dirv[0].t.num = 14'h30; dirv[0].t.dest = 5'd5;
        dirv[0].rdv = {4{32'h1234}};
        dirv[0].exp[0] = '0; dirv[0].exp[0].re = 1'b1; dirv[0].exp[0].rnum = 14'h30;
        dirv[0].exp[1] = '0; dirv[0].exp[1].rfwe = 1'b1; dirv[0].exp[1].waddr = 5'd5;
        dirv[0].exp[1].rfwdata = 32'h1234;

        dnames[1] = "csrxchg";
        dirv[1].t.op = 3'd3; dirv[1].t.num = 14'h0; dirv[1].t.rj = 32'h3;
        dirv[1].t.rd = 32'h7; dirv[1].t.dest = 5'd9;
        dirv[1].rdv = {4{32'h8}};
        dirv[1].exp[0] = '0; dirv[1].exp[0].re = 1'b1;
        dirv[1].exp[1] = '0; dirv[1].exp[1].we = 4'hf; dirv[1].exp[1].wmask = 32'h3;
        dirv[1].exp[1].wdata = 32'h7;
        dirv[1].exp[2] = '0; dirv[1].exp[2].rfwe = 1'b1; dirv[1].exp[2].waddr = 5'd9;
        dirv[1].exp[2].rfwdata = 32'h8;

        dnames[2] = "ws_ex";
        dirv[2].t.op = 3'd2; dirv[2].t.ex = 1'b1; dirv[2].t.ecode = 6'h0b;
        dirv[2].t.pc = 32'h1c00_0100; dirv[2].t.dest = 5'd3;
        dirv[2].xpv = {4{32'h1c00_8000}};
        dirv[2].exp[0] = '0; dirv[2].exp[0].wbex = 1'b1; dirv[2].exp[0].ecode = 6'h0b;
        dirv[2].exp[0].wbpc = 32'h1c00_0100;
        dirv[2].exp[1] = '0; dirv[2].exp[1].flush = 1'b1; dirv[2].exp[1].fpc = 32'h1c00_8000;

        dnames[3] = "int_over_csrwr";
        dirv[3].t.op = 3'd2; dirv[3].t.hasint = 1'b1; dirv[3].t.ecode = 6'h3f;
        dirv[3].t.esub = 9'd5; dirv[3].t.pc = 32'h1c00_0200; dirv[3].t.dest = 5'd4;
        dirv[3].xpv = {4{32'h1c00_8000}};
        dirv[3].exp[0] = '0; dirv[3].exp[0].wbex = 1'b1; dirv[3].exp[0].wbpc = 32'h1c00_0200;
        dirv[3].exp[1] = '0; dirv[3].exp[1].flush = 1'b1; dirv[3].exp[1].fpc = 32'h1c00_8000;

        dnames[4] = "ertn";
        dirv[4].t.op = 3'd4;
        dirv[4].epv = {4{32'h1c00_0204}};
        dirv[4].exp[0] = '0; dirv[4].exp[0].ertn = 1'b1;
        dirv[4].exp[1] = '0; dirv[4].exp[1].flush = 1'b1; dirv[4].exp[1].fpc = 32'h1c00_0204;

        dnames[5] = "csrrd_dest0";
        dirv[5].t.op = 3'd1; dirv[5].t.num = 14'h3fff; dirv[5].t.dest = 5'd0;
        dirv[5].rdv = {4{32'hdead_beef}};
        dirv[5].exp[0] = '0; dirv[5].exp[0].re = 1'b1; dirv[5].exp[0].rnum = 14'h3fff;
        dirv[5].exp[1] = '0; dirv[5].exp[1].rfwdata = 32'hdead_beef;

        dnames[6] = "op7_is_none";
        dirv[6].t.op = 3'd7; dirv[6].t.num = 14'h12; dirv[6].t.dest = 5'd1;

        resetn      = 1'b0;
        ws_valid    = 1'b0;
        ws_op       = '0;
        ws_csr_num  = '0;
        ws_rj_value = '0;
        ws_rd_value = '0;
        ws_dest     = '0;
        ws_pc       = '0;
        ws_ex       = 1'b0;
        ws_ecode    = '0;
        ws_esubcode = '0;
        has_int     = 1'b0;
        csr_rdata   = '0;
        excp_pc     = '0;
        ertn_pc     = '0;

        @(negedge clk);
        #1 check_quiet("in_reset");
        resetn = 1'b1;
        #1 check(act, idle_obs(), "after_reset");

        for (int i = 0; i < 7; i++) run_txn(dirv[i], dnames[i]);

        // Reset pulled while the CSR write strobe is up.
        v = '0;
        v.t.op = 3'd2; v.t.num = 14'h55; v.t.rd = 32'hcafe_f00d; v.t.dest = 5'd7;
        apply(v.t);
        @(negedge clk);
        junk();
        csr_rdata = 32'h1111_2222;
        #1 check({act.re, act.rnum}, {1'b1, 14'h55, 203'd0} >> 203, "rst_seq read");
        @(negedge clk);
        junk();
        #1 check({act.we, act.wnum, act.wdata}, {4'hf, 14'h55, 32'hcafe_f00d}, "rst_seq write");
        #1 resetn = 1'b0;
        #1 check_quiet("rst_seq we_drop");
        @(negedge clk);
        ws_valid = 1'b0;
        #1 check_quiet("rst_seq held");
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1 check(act, idle_obs(), $sformatf("rst_seq no_rf c%0d", k));
        end

        v = '0;
        v.t.op = 3'd1; v.t.num = 14'h30; v.t.dest = 5'd12;
        v.rdv = {32'h4, 32'h3, 32'h2, 32'h5678_9abc};
        v.exp = model(v);
        run_txn(v, "rst_seq csrrd");

        for (int i = 0; i < 200; i++) begin
            v.t.op     = 3'($urandom_range(0, 7));
            v.t.num    = 14'($urandom);
            v.t.rj     = $urandom;
            v.t.rd     = $urandom;
            v.t.dest   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            v.t.pc     = $urandom;
            v.t.ex     = ($urandom_range(0, 5) == 0);
            v.t.ecode  = 6'($urandom);
            v.t.esub   = 9'($urandom);
            v.t.hasint = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 4; k++) begin
                v.rdv[k] = $urandom;
                v.xpv[k] = $urandom;
                v.epv[k] = $urandom;
            end
            v.exp = model(v);
            run_txn(v, $sformatf("rand%0d op%0d", i, v.t.op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
